// File: rtl/uart_pkt_pkg.sv
// Constants, CRC helper and frame FSM encoding shared by the packet UART blocks.
package uart_pkt_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hA5;
    localparam logic [7:0] EOF_BYTE  = 8'h5A;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    // One byte of CRC-8 (MSB first, no reflection, no final XOR).
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 character shifter with baud counter.
// txd is taken straight from the low bit of the shift register, so the pin is a
// flop output and idles high through the ones shifted in behind the stop bit.
module uart_byte_tx #(
    parameter int BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       load,
    input  logic [7:0] din,
    output logic       txd,
    output logic       bit_done_last
);
    localparam int CW = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 2;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(BPS_CNT - 2);

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_r;
    logic          active;

    assign txd = shift_r[0];

    // Asserted one cycle before the stop bit's final cycle, so the frame FSM can
    // spend that final cycle in LOAD and reload with no gap.
    assign bit_done_last = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_PRE);

    // Baud counter and shifter; a load restarts the character immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shift_r  <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
        end else if (load) begin
            shift_r  <= {1'b1, din, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b1;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                shift_r  <= {1'b1, shift_r[9:1]};
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte packet transmitter: SOF, func, payload, CRC8, EOF sent back to back.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for send_start
//   ST_LOAD  | pick frame byte byte_cnt, fold it into the CRC, load shifter
//   ST_SHIFT | character on the line, wait for its last stop-bit cycle
//   ST_DONE  | last stop-bit cycle of the frame; tx_done/tx_busy update next
module uart_mult_byte_tx
    import uart_pkt_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int MAX_BYTES = 11
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   send_start,
    input  logic [7:0]             func,
    input  logic [3:0]             pay_len,
    input  logic [MAX_BYTES*8-1:0] tx_data,
    output logic                   uart_txd,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [3:0]             byte_idx
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

    tx_state_t  state, state_nxt;
    logic [7:0] func_r;
    logic [3:0] len_r;
    logic [7:0] pay_r [MAX_BYTES];
    logic [7:0] crc_r;
    logic [3:0] byte_cnt;
    logic [3:0] pay_idx;
    logic [7:0] sel_byte;
    logic       load;
    logic       accept;
    logic       bit_done_last;

    assign accept  = (state == ST_IDLE) && send_start;
    assign pay_idx = byte_cnt - 4'd2;

    // Frame state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state; byte_cnt already points past the byte on the line during SHIFT.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE:  if (send_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (bit_done_last) begin
                state_nxt = (byte_cnt == len_r + 4'd4) ? ST_DONE : ST_LOAD;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Frame byte selected by position.
    always_comb begin
        sel_byte = EOF_BYTE;
        if (byte_cnt == 4'd0)                 sel_byte = SOF_BYTE;
        else if (byte_cnt == 4'd1)            sel_byte = func_r;
        else if (byte_cnt <= len_r + 4'd1)    sel_byte = pay_r[pay_idx];
        else if (byte_cnt == len_r + 4'd2)    sel_byte = crc_r;
    end

    // Capture on accept, CRC and byte counters on load, status flags at frame end.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            func_r   <= '0;
            len_r    <= '0;
            for (int i = 0; i < MAX_BYTES; i++) pay_r[i] <= '0;
            crc_r    <= '0;
            byte_cnt <= '0;
            byte_idx <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept) begin
                func_r   <= func;
                len_r    <= (pay_len > MAX_LEN) ? MAX_LEN : pay_len;
                for (int i = 0; i < MAX_BYTES; i++) pay_r[i] <= tx_data[i*8 +: 8];
                crc_r    <= '0;
                byte_cnt <= '0;
                byte_idx <= '0;
                tx_busy  <= 1'b1;
            end
            if (load) begin
                byte_cnt <= byte_cnt + 4'd1;
                byte_idx <= byte_cnt;
                if ((byte_cnt != 4'd0) && (byte_cnt <= len_r + 4'd1)) begin
                    crc_r <= crc8_next(crc_r, sel_byte);
                end
            end
            if (state == ST_DONE) begin
                tx_done <= 1'b1;
                tx_busy <= 1'b0;
            end
        end
    end

    uart_byte_tx #(
        .BPS_CNT(BPS_CNT)
    ) u_byte_tx (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .load          (load),
        .din           (sel_byte),
        .txd           (uart_txd),
        .bit_done_last (bit_done_last)
    );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx. A frame-level model predicts the serial line,
// tx_busy, tx_done and byte_idx as arithmetic on the cycle offset from the
// accepting edge; a monitor compares every cycle. Baud is shortened to 8 clocks.
module tb_uart_mult_byte_tx;
    localparam int CLK_FREQ  = 921_600;
    localparam int UART_BPS  = 115_200;
    localparam int MAX_BYTES = 11;
    localparam int B         = CLK_FREQ / UART_BPS;
    localparam int BYTE_T    = 10 * B;
    localparam int LIMIT     = 20 * BYTE_T;

    typedef logic [15:0][7:0] frame_t;

    logic                   sys_clk;
    logic                   sys_rst;
    logic                   send_start;
    logic [7:0]             func;
    logic [3:0]             pay_len;
    logic [MAX_BYTES*8-1:0] tx_data;
    logic                   uart_txd;
    logic                   tx_busy;
    logic                   tx_done;
    logic [3:0]             byte_idx;

    uart_mult_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .MAX_BYTES(MAX_BYTES)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .send_start(send_start),
        .func      (func),
        .pay_len   (pay_len),
        .tx_data   (tx_data),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .byte_idx  (byte_idx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int     n_tests = 0;
    int     n_fail  = 0;

    // model state
    bit     live      = 1'b0;
    int     acc_edge  = 0;
    int     edge_cnt  = 0;
    frame_t frm       = '0;
    int     frm_n     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial CRC-8, poly x^8+x^2+x+1, data fed MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c, v;
        logic       fb;
        c = crc;
        v = d;
        for (int i = 0; i < 8; i++) begin
            fb = c[7] ^ v[7];
            v  = {v[6:0], 1'b0};
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic int frame_len(input logic [3:0] l);
        return ((int'(l) > MAX_BYTES) ? MAX_BYTES : int'(l)) + 4;
    endfunction

    function automatic frame_t build_frame(input logic [7:0] f, input logic [3:0] l,
                                           input logic [MAX_BYTES*8-1:0] d);
        frame_t                 fr;
        logic [7:0]             c;
        logic [MAX_BYTES*8-1:0] t;
        int                     np;
        np = frame_len(l) - 4;
        fr = '0;
        fr[0] = 8'hA5;
        fr[1] = f;
        c = ref_crc(8'h00, f);
        for (int i = 0; i < np; i++) begin
            t = d >> (8 * i);
            fr[4'(2 + i)] = t[7:0];
            c = ref_crc(c, t[7:0]);
        end
        fr[4'(np + 2)] = c;
        fr[4'(np + 3)] = 8'h5A;
        return fr;
    endfunction

    // Line level j cycles after the accepting edge: start bit begins one edge later.
    function automatic logic exp_txd_f(input int j);
        int         k, bt, by, pos;
        logic [7:0] cur;
        k = j - 1;
        if (!live || k < 0 || k >= frm_n * BYTE_T) return 1'b1;
        bt  = k / B;
        by  = bt / 10;
        pos = bt % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        cur = frm[4'(by)];
        return cur[3'(pos - 1)];
    endfunction

    task automatic send(input logic [7:0] f, input logic [3:0] l, input logic [MAX_BYTES*8-1:0] d);
        @(posedge sys_clk); #2;
        send_start = 1'b1;
        func       = f;
        pay_len    = l;
        tx_data    = d;
        @(posedge sys_clk); #2;
        send_start = 1'b0;
    endtask

    // Returns at the falling edge inside the tx_done cycle.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge sys_clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    frame_t fr1;
    frame_t lit1;
    int     cnt;

    initial begin
        sys_rst    = 1'b1;
        send_start = 1'b0;
        func       = '0;
        pay_len    = '0;
        tx_data    = '0;

        fork
            // model: tracks edges and frame acceptance as the DUT should see them
            begin
                int  prev, jp;
                bit  busy_prev;
                forever begin
                    @(posedge sys_clk or posedge sys_rst);
                    if (sys_rst) begin
                        live = 1'b0;
                    end else begin
                        prev      = edge_cnt;
                        jp        = prev - acc_edge;
                        busy_prev = live && (jp < 1 + frm_n * BYTE_T);
                        if (send_start && !busy_prev) begin
                            frm      = build_frame(func, pay_len, tx_data);
                            frm_n    = frame_len(pay_len);
                            acc_edge = prev + 1;
                            live     = 1'b1;
                        end
                        edge_cnt = prev + 1;
                    end
                end
            end
            // monitor: compare outputs against the model every cycle
            begin
                int   j;
                logic e_txd, e_busy, e_done;
                forever begin
                    @(negedge sys_clk);
                    j = edge_cnt - acc_edge;
                    if (sys_rst) begin
                        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
                    end else begin
                        e_txd  = exp_txd_f(j);
                        e_busy = live && (j < 1 + frm_n * BYTE_T);
                        e_done = live && (j == 1 + frm_n * BYTE_T);
                    end
                    check("line_txd", 32'(uart_txd), 32'(e_txd));
                    check("line_busy", 32'(tx_busy), 32'(e_busy));
                    check("line_done", 32'(tx_done), 32'(e_done));
                    if (!sys_rst && live && j >= 1 && (j - 1) < frm_n * BYTE_T)
                        check("byte_idx", 32'(byte_idx), 32'((j - 1) / BYTE_T));
                end
            end
        join_none

        // reset values
        #2;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_byte_idx", 32'(byte_idx), 32'd0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b0;

        // hand-computed pins on the model itself
        check("pin_crc_80", 32'(ref_crc(8'h00, 8'h80)), 32'h89);
        check("pin_len_clamp", 32'(frame_len(4'd15)), 32'd15);
        check("pin_len_empty", 32'(frame_len(4'd0)), 32'd4);
        fr1  = build_frame(8'h31, 4'd8, {24'h0, 64'h3938373635343332});
        lit1 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hF4, 8'h39, 8'h38,
                8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'hA5};
        for (int i = 0; i < 16; i++)
            check("pin_frame1", 32'(fr1[4'(i)]), 32'(lit1[4'(i)]));

        // 1: CRC check vector, 12-byte frame
        send(8'h31, 4'd8, {24'h0, 64'h3938373635343332});
        wait_done("t1_done");
        repeat (5) @(negedge sys_clk);

        // 2: empty payload; busy from accept edge to the edge after the last stop bit
        send(8'h80, 4'd0, {MAX_BYTES{8'hC6}});
        cnt = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge sys_clk);
            if (tx_busy) cnt++;
            else break;
        end
        check("t2_busy_in_range", 32'((cnt >= 4 * BYTE_T) && (cnt <= 4 * BYTE_T + 2)), 32'd1);
        if (!((cnt >= 4 * BYTE_T) && (cnt <= 4 * BYTE_T + 2)))
            $display("  t2 busy cycles=%0d required=%0d +/-1", cnt, 4 * BYTE_T + 1);
        repeat (5) @(negedge sys_clk);

        // 3: pay_len above the maximum is clamped
        send(8'h42, 4'd15, 88'h0B0A090807060504030201);
        wait_done("t3_done");
        repeat (5) @(negedge sys_clk);

        // 4: send_start mid-frame with new data is ignored
        send(8'h10, 4'd3, {64'h0, 24'h993CC3});
        repeat (2 * BYTE_T) @(posedge sys_clk);
        send(8'hEE, 4'd5, {MAX_BYTES{8'hFF}});
        wait_done("t4_done");
        repeat (3 * BYTE_T) @(negedge sys_clk);
        check("t4_no_second_frame", 32'(tx_busy), 32'd0);

        // 5: back-to-back, new request during the tx_done cycle
        send(8'h21, 4'd2, {72'h0, 16'hBEEF});
        wait_done("t5a_done");
        #1;
        send_start = 1'b1;
        func       = 8'h22;
        pay_len    = 4'd3;
        tx_data    = {64'h0, 24'h010203};
        @(posedge sys_clk); #2;
        send_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (uart_txd) cnt++;
            else break;
        end
        check("t5_idle_gap", 32'(cnt), 32'd1);
        wait_done("t5b_done");
        repeat (5) @(negedge sys_clk);

        // 6: reset during a zero data bit of payload byte 3, then a clean frame
        send(8'h77, 4'd6, {40'h0, 48'h554400332211});
        repeat (1 + 5 * BYTE_T + 3 * B) @(posedge sys_clk);
        #2;
        check("t6_pre_txd", 32'(uart_txd), 32'd0);
        sys_rst = 1'b1;
        #1;
        check("t6_async_txd", 32'(uart_txd), 32'd1);
        check("t6_async_busy", 32'(tx_busy), 32'd0);
        check("t6_async_done", 32'(tx_done), 32'd0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        repeat (2 * BYTE_T) @(negedge sys_clk);
        send(8'h55, 4'd3, {64'h0, 24'hA1B2C3});
        wait_done("t6_after_done");
        repeat (5) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mult_byte_tx.md
# uart_mult_byte_tx

Multi-byte UART packet transmitter: the transmit-side counterpart of the multi-byte packet receiver. It accepts one function byte plus up to `MAX_BYTES` payload bytes in parallel and frames them as SOF, function, payload, CRC8 and EOF. It serialises the frame 8N1 on `uart_txd` in the 50 MHz domain. It sits beside the register mapper and returns status or echo packets to the host.

## Interface

**Parameters**
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `UART_BPS`, 115200: baud rate. `BPS_CNT = CLK_FREQ/UART_BPS` (434 at the defaults).
- `MAX_BYTES`, 11: maximum payload byte count.

**Ports** (one clock; reset is asynchronous and active-high)
- `sys_clk`, in, 1: system clock (`clk_50M`).
- `sys_rst`, in, 1: asynchronous, active-high reset.
- `send_start`, in, 1: single-cycle request that launches a frame.
- `func`, in, 8: function byte.
- `pay_len`, in, 4: number of payload bytes (0..`MAX_BYTES`).
- `tx_data`, in, `MAX_BYTES*8`: payload bytes. Byte k is `tx_data[8k+7:8k]`, and byte 0 is sent first.
- `uart_txd`, out, 1: serial line. Idles high.
- `tx_busy`, out, 1: high from frame accept until the last stop bit ends.
- `tx_done`, out, 1: one-cycle pulse at frame end.
- `byte_idx`, out, 4: index of the frame byte currently on the line (0 = SOF).

## Operation

**Frame format**
- SOF `8'hA5`, then `func`, then `pay_len` payload bytes, then CRC8, then EOF `8'h5A`.
- Frame length is `pay_len + 4` bytes.

**CRC8**
- Polynomial 0x07, init 0x00, no reflection, no final XOR.
- Computed over `func` and the payload bytes in transmission order.
- The CRC is updated byte-serially as each byte is loaded into the shifter, so it is final before its slot is loaded.

**Character format**
- Start bit 0, 8 data bits LSB first, 1 stop bit.
- Each bit lasts exactly `BPS_CNT` cycles.

**Input capture**
- `send_start` while idle captures `func`, `pay_len` and `tx_data` into internal registers.
- `pay_len > MAX_BYTES` is clamped to `MAX_BYTES`.
- `pay_len` = 0 is legal and produces a 4-byte frame.
- `send_start` while `tx_busy` is ignored, with no queueing, and the captured registers do not change.

**Frame FSM**
- IDLE: wait for `send_start`, then go to LOAD.
- LOAD: select the frame byte for `byte_idx`, update the CRC if the byte is function or payload, then go to SHIFT.
- SHIFT: 10 bit periods through the sub-module. On completion go to LOAD if bytes remain, otherwise go to DONE.
- DONE: pulse `tx_done`, clear `tx_busy`, return to IDLE.

**Byte selection for `byte_idx`**
- 0: SOF.
- 1: `func`.
- 2 to `pay_len+1`: payload byte `byte_idx-2`.
- `pay_len+2`: CRC.
- `pay_len+3`: EOF.

**Reset**
- All outputs: `uart_txd` = 1, `tx_busy` = 0, `tx_done` = 0, `byte_idx` = 0.
- The CRC register is cleared and the FSM is in IDLE.
- Reset mid-frame drives the line high immediately (asynchronous) and abandons the frame. No `tx_done` is issued.

## Timing

- `send_start` sampled high at edge 0: `tx_busy` = 1 after edge 0, and the `uart_txd` start bit begins after edge 1.
- No idle gap between bytes. The LOAD cycle overlaps the last stop-bit cycle, so the byte pitch is exactly `10*BPS_CNT` cycles.
- Frame duration from start-bit fall to stop-bit end: `(pay_len+4)*10*BPS_CNT` cycles.
- `tx_done` is high for the single cycle after the final stop bit's `BPS_CNT` count completes. `tx_busy` falls on that same edge.
- A new `send_start` is accepted on the cycle `tx_done` is high (back-to-back frames).
- The baud counter runs 0..`BPS_CNT-1` and wraps. Bit counter width is 4 bits, byte counter width is 4 bits.
- `uart_txd` is registered: no combinational path from inputs to the pin.

## Structure

**Shared package `uart_pkt_pkg`**
- `SOF_BYTE` = 8'hA5 and `EOF_BYTE` = 8'h5A. These are shared with the receiver.
- `CRC8_POLY` = 8'h07.
- The `crc8_next(crc, byte)` function.
- FSM state encoding.

**Sub-module `uart_byte_tx`**
- Baud counter and 10-bit shifter.
- Ports: `load`, `din[7:0]`, `txd`, `bit_done_last`.
- The frame FSM, byte mux and CRC stay in the top module.

## Test plan

1. **CRC check vector.** Stimulus: `func` = 0x31, `pay_len` = 8, payload "23456789" (0x32..0x39). Required: bench UART decoder reads A5 31 32..39 F4 5A, and `tx_done` pulses once after 12 bytes.
2. **Empty payload.** Stimulus: `pay_len` = 0, `func` = 0x80. Required: frame A5 80 CRC(0x80) 5A, and `tx_busy` lasts 4*10*434 cycles ±1.
3. **Clamp.** Stimulus: `pay_len` = 15. Required: exactly 11 payload bytes, 15-byte frame, CRC over `func` plus 11 bytes.
4. **Busy rejection.** Stimulus: pulse `send_start` with different data mid-frame. Required: the frame is unchanged, and no second frame starts after `tx_done`.
5. **Back-to-back.** Stimulus: `send_start` on the `tx_done` cycle. Required: the next start bit follows after 1 cycle of idle high, and the second frame is correct.
6. **Reset mid-frame.** Stimulus: assert `sys_rst` during payload byte 3. Required: `uart_txd` = 1 without waiting for a clock edge, `tx_busy` = 0, no `tx_done`, and a subsequent frame is correct.
